// File: rtl/modn_cnt_pkg.sv
// rtl/modn_cnt_pkg.sv - shared types and parameter checks for the mod-N up/down counter
package modn_cnt_pkg;

    typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} dir_e;

    function automatic bit modn_params_ok(input int width, input int modulus, input int step_w);
        return (modulus >= 2) && (modulus <= (1 << width)) &&
               (((1 << step_w) - 1) <= (modulus - 1));
    endfunction

endpackage

// File: rtl/modn_step_calc.sv
// rtl/modn_step_calc.sv - next-count and wrap/saturate calculator (MODN_CNT_SATURATE_EN selects saturation)
module modn_step_calc
    import modn_cnt_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 12,
    parameter int STEP_W  = 2
) (
    input  logic [WIDTH-1:0]  count,
    input  logic [STEP_W-1:0] step,
    input  dir_e              dir,
    output logic [WIDTH-1:0]  next,
    output logic              wrap
);

    localparam logic [WIDTH:0] MOD_W = (WIDTH+1)'(MODULUS);

    logic [WIDTH:0] cnt_x;
    logic [WIDTH:0] step_x;
    logic [WIDTH:0] sum;

    assign cnt_x  = {1'b0, count};
    assign step_x = (WIDTH+1)'(step);
    assign sum    = cnt_x + step_x;

    always_comb begin
        next = count;
        wrap = 1'b0;
`ifdef MODN_CNT_SATURATE_EN
        // wrap here means the requested step was truncated at a limit
        if (dir == DIR_UP) begin
            if (sum >= MOD_W) begin
                next = WIDTH'(MOD_W - 1'b1);
                wrap = 1'b1;
            end else begin
                next = WIDTH'(sum);
            end
        end else begin
            if (cnt_x >= step_x) begin
                next = WIDTH'(cnt_x - step_x);
            end else begin
                next = '0;
                wrap = 1'b1;
            end
        end
`else
        if (dir == DIR_UP) begin
            if (sum >= MOD_W) begin
                next = WIDTH'(sum - MOD_W);
                wrap = 1'b1;
            end else begin
                next = WIDTH'(sum);
            end
        end else begin
            if (cnt_x >= step_x) begin
                next = WIDTH'(cnt_x - step_x);
            end else begin
                next = WIDTH'(cnt_x + MOD_W - step_x);
                wrap = 1'b1;
            end
        end
`endif
    end

endmodule

// File: rtl/modn_updown_counter.sv
// rtl/modn_updown_counter.sv - loadable mod-N up/down counter with step, tc and wrap flags (MODN_CNT_SATURATE_EN)
module modn_updown_counter
    import modn_cnt_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 12,
    parameter int STEP_W  = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic              load,
    input  logic              mode,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  data_in,
    output logic [WIDTH-1:0]  data_out,
    output logic              wrap,
    output logic              load_err,
    output logic              tc
);

    if (!modn_params_ok(WIDTH, MODULUS, STEP_W)) begin : g_bad_params
        $fatal(1, "modn_updown_counter: illegal WIDTH/MODULUS/STEP_W combination");
    end

    localparam logic [WIDTH:0]   MOD_W   = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] calc_next;
    logic             calc_wrap;
    logic             load_oob;
    dir_e             dir;

    assign dir      = dir_e'(mode);
    assign load_oob = ({1'b0, data_in} >= MOD_W);

    modn_step_calc #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS),
        .STEP_W  (STEP_W)
    ) u_step_calc (
        .count (data_out),
        .step  (step),
        .dir   (dir),
        .next  (calc_next),
        .wrap  (calc_wrap)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out <= '0;
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else if (load) begin
            data_out <= load_oob ? MAX_CNT : data_in;
            wrap     <= 1'b0;
            load_err <= load_oob;
        end else if (en) begin
            data_out <= calc_next;
            wrap     <= calc_wrap;
            load_err <= 1'b0;
        end else begin
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end
    end

    // Combinational so a cascaded stage can use it as its enable in the same cycle
    assign tc = en & ((mode & (data_out == MAX_CNT)) | (~mode & (data_out == '0)));

endmodule

// File: tb/tb_modn_updown_counter.sv
// tb/tb_modn_updown_counter.sv - scoreboard bench for modn_updown_counter (honours MODN_CNT_SATURATE_EN)
module tb_modn_updown_counter;

    localparam int W  = 4;
    localparam int M  = 12;
    localparam int SW = 2;

    typedef struct {
        int cnt;
        bit wrap;
        bit lerr;
        bit tc;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          en = 1'b0;
    logic          load = 1'b0;
    logic          mode = 1'b0;
    logic [SW-1:0] step = '0;
    logic [W-1:0]  data_in = '0;
    logic [W-1:0]  data_out;
    logic          wrap;
    logic          load_err;
    logic          tc;

    int   n_checks = 0;
    int   n_fail = 0;
    int   model_cnt = 0;
    exp_t exp_q[$];

    modn_updown_counter #(.WIDTH(W), .MODULUS(M), .STEP_W(SW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (en),
        .load     (load),
        .mode     (mode),
        .step     (step),
        .data_in  (data_in),
        .data_out (data_out),
        .wrap     (wrap),
        .load_err (load_err),
        .tc       (tc)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endfunction

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("data_out", int'(data_out), e.cnt);
            check("wrap", int'(wrap), int'(e.wrap));
            check("load_err", int'(load_err), int'(e.lerr));
            check("tc", int'(tc), int'(e.tc));
        end
    end

    // Reference: counting is modular (or clamped) arithmetic on plain integers
    task automatic drive(input bit ld, input bit e, input bit md, input int st, input int din);
        exp_t x;
        @(negedge clk);
        load = ld; en = e; mode = md; step = SW'(st); data_in = W'(din);
        x.wrap = 0;
        x.lerr = 0;
        if (ld) begin
            x.lerr = (din >= M);
            model_cnt = (din >= M) ? M - 1 : din;
        end else if (e) begin
            int target;
            target = md ? model_cnt + st : model_cnt - st;
`ifdef MODN_CNT_SATURATE_EN
            x.wrap = (target > M - 1) || (target < 0);
            model_cnt = (target > M - 1) ? M - 1 : (target < 0 ? 0 : target);
`else
            x.wrap = (target >= M) || (target < 0);
            model_cnt = (target + M) % M;
`endif
        end
        x.cnt = model_cnt;
        x.tc  = e && ((md && model_cnt == M - 1) || (!md && model_cnt == 0));
        exp_q.push_back(x);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        check("reset data_out", int'(data_out), 0);

        // up across the modulus
        drive(1, 0, 1, 0, 10);
        for (int i = 0; i < 3; i++) drive(0, 1, 1, 1, 0);
        // down with multi-step
        drive(1, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) drive(0, 1, 0, 3, 0);
        // load clamp, load beats en, load with en low
        drive(1, 1, 1, 2, 14);
        drive(1, 0, 1, 0, 5);
        drive(1, 0, 0, 0, 15);
        drive(1, 1, 0, 3, 11);
        // hold cases
        drive(1, 0, 0, 0, 6);
        for (int i = 0; i < 4; i++) drive(0, 0, int'($urandom_range(0, 1)), 3, 0);
        for (int i = 0; i < 3; i++) drive(0, 1, int'($urandom_range(0, 1)), 0, 0);
        // saturation-specific corners (modular build just wraps)
        drive(1, 0, 1, 0, 10);
        drive(0, 1, 1, 3, 0);
        drive(0, 1, 1, 3, 0);
        drive(1, 0, 0, 0, 2);
        drive(0, 1, 0, 3, 0);
        drive(0, 1, 0, 1, 0);
        // direction change mid-count
        drive(1, 0, 1, 0, 4);
        drive(0, 1, 1, 2, 0);
        drive(0, 1, 0, 3, 0);
        drive(0, 1, 1, 1, 0);

        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 7) == 0), bit'($urandom_range(0, 1) | $urandom_range(0, 1)),
                  bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
        end

        // asynchronous reset between edges at count 7
        drive(1, 0, 1, 0, 7);
        drive(0, 0, 1, 0, 0);
        @(negedge clk);
        load = 0; en = 0;
        check("pre-reset data_out", int'(data_out), 7);
        #2 reset_n = 1'b0;
        #1;
        check("async reset data_out", int'(data_out), 0);
        check("async reset wrap", int'(wrap), 0);
        check("async reset load_err", int'(load_err), 0);
        @(negedge clk);
        check("held reset data_out", int'(data_out), 0);
        reset_n = 1'b1;
        model_cnt = 0;
        drive(0, 1, 1, 2, 0);
        drive(0, 1, 0, 3, 0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        check("scoreboard drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
